mem_req_arbiter: RTL and testbench

- Arbitrates two SRAM-like requesters onto one shared downstream SRAM-like memory port:
  - instruction fetch (IF stage);
  - data access (MEM stage load/store).
- Tracks outstanding requests in an in-order ID FIFO and routes each downstream response back to its originator.
- Sits between the pipeline stages and the memory bridge.
- Replaces separate inst/data memory ports once the single-bus memory system is integrated.

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_req_arbiter_if.sv | 24 ++
 rtl/id_fifo.sv | 54 +++++
 rtl/mem_req_arbiter.sv | 119 +++++++++++
 tb/tb_mem_req_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the single-bus SRAM-like memory system.
package mem_bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } arb_state_e;

    // Request payload that follows the winning requester onto the memory port
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bus; master issues requests, slave accepts and answers.
interface mem_req_arbiter_if;

    logic                           req;
    logic                           wr;
    logic [1:0]                     size;
    logic [mem_bus_pkg::STRB_W-1:0] wstrb;
    logic [mem_bus_pkg::ADDR_W-1:0] addr;
    logic [mem_bus_pkg::DATA_W-1:0] wdata;
    logic                           addr_ok;
    logic                           data_ok;
    logic [mem_bus_pkg::DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/id_fifo.sv
// Synchronous in-order ID FIFO without push/pop bypass.
module id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging IF and MEM requesters onto one memory port,
// with an in-order ID FIFO steering each response back to its originator.
module mem_req_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_req_arbiter_if.slave         inst_bus,
    mem_req_arbiter_if.slave         data_bus,
    mem_req_arbiter_if.master        mem_bus,
    output logic                     resp_err
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_last_grant;
    logic       r_resp_err;

    logic       w_sel;
    logic       w_mem_req;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_head;
    logic       w_inst_elig;
    logic       w_data_elig;
    mem_req_t   w_inst_pl;
    mem_req_t   w_data_pl;
    mem_req_t   w_mem_pl;

    assign w_inst_elig = inst_bus.req & ~w_full;
    assign w_data_elig = data_bus.req & ~w_full;

    assign w_inst_pl = {inst_bus.wr, inst_bus.size, inst_bus.wstrb, inst_bus.addr, inst_bus.wdata};
    assign w_data_pl = {data_bus.wr, data_bus.size, data_bus.wstrb, data_bus.addr, data_bus.wdata};
    assign w_mem_pl  = (w_sel == REQ_DATA) ? w_data_pl : w_inst_pl;

    // Grant selection; a presented-but-unaccepted request stays locked to its owner
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = REQ_INST;
        w_mem_req   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_inst_elig && w_data_elig) begin
                    w_mem_req = 1'b1;
                    w_sel     = ~r_last_grant;
                end else if (w_data_elig) begin
                    w_mem_req = 1'b1;
                    w_sel     = REQ_DATA;
                end else if (w_inst_elig) begin
                    w_mem_req = 1'b1;
                end
                if (w_mem_req && !mem_bus.addr_ok) begin
                    w_state_nxt = (w_sel == REQ_DATA) ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I: begin
                w_mem_req = inst_bus.req;
                if (!inst_bus.req || mem_bus.addr_ok) w_state_nxt = IDLE;
            end
            LOCK_D: begin
                w_sel     = REQ_DATA;
                w_mem_req = data_bus.req;
                if (!data_bus.req || mem_bus.addr_ok) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_INST;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_last_grant <= w_sel;
            if (mem_bus.data_ok && w_empty) r_resp_err <= 1'b1;
        end
    end

    assign w_push = w_mem_req & mem_bus.addr_ok;
    assign w_pop  = mem_bus.data_ok & ~w_empty;

    id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (1)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_sel),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign mem_bus.req   = w_mem_req;
    assign mem_bus.wr    = w_mem_pl.wr;
    assign mem_bus.size  = w_mem_pl.size;
    assign mem_bus.wstrb = w_mem_pl.wstrb;
    assign mem_bus.addr  = w_mem_pl.addr;
    assign mem_bus.wdata = w_mem_pl.wdata;

    assign inst_bus.addr_ok = w_push & (w_sel == REQ_INST);
    assign data_bus.addr_ok = w_push & (w_sel == REQ_DATA);
    assign inst_bus.data_ok = w_pop & (w_head == REQ_INST);
    assign data_bus.data_ok = w_pop & (w_head == REQ_DATA);
    assign inst_bus.rdata   = mem_bus.rdata;
    assign data_bus.rdata   = mem_bus.rdata;

    assign resp_err = r_resp_err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed plus randomized bench for mem_req_arbiter against a queue-based reference model.
module tb_mem_req_arbiter;
    import mem_bus_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic resp_err;

    always #5 clk = ~clk;

    mem_req_arbiter_if inst_b ();
    mem_req_arbiter_if data_b ();
    mem_req_arbiter_if mem_b ();

    mem_req_arbiter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst_bus (inst_b),
        .data_bus (data_b),
        .mem_bus  (mem_b),
        .resp_err (resp_err)
    );

    // stimulus
    mem_req_t    i_pl, d_pl;
    logic        i_req, d_req, m_aok, m_dok;
    logic [31:0] m_rdata;

    // reference model: outstanding IDs in order, who last won, who is waiting on an accept
    bit idq[$];
    bit mdl_last;
    int mdl_waiting;
    bit mdl_err;
    int acc_id;
    int rsp_id;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        inst_b.req = i_req;   inst_b.wr = i_pl.wr;     inst_b.size = i_pl.size;
        inst_b.wstrb = i_pl.wstrb; inst_b.addr = i_pl.addr; inst_b.wdata = i_pl.wdata;
        data_b.req = d_req;   data_b.wr = d_pl.wr;     data_b.size = d_pl.size;
        data_b.wstrb = d_pl.wstrb; data_b.addr = d_pl.addr; data_b.wdata = d_pl.wdata;
        mem_b.addr_ok = m_aok; mem_b.data_ok = m_dok;  mem_b.rdata = m_rdata;
    endtask

    task automatic model_reset();
        idq.delete();
        mdl_last    = 1'b0;
        mdl_waiting = -1;
        mdl_err     = 1'b0;
    endtask

    // One clock cycle: apply inputs, compare every output with the model, advance the model
    task automatic step();
        bit full, mreq, acc, dv, head, sel, was_empty;
        mem_req_t pl;
        @(negedge clk);
        drive();
        #1;
        full      = (idq.size() == DEPTH);
        was_empty = (idq.size() == 0);
        mreq      = 1'b0;
        sel       = 1'b0;
        if (mdl_waiting >= 0) begin
            sel  = (mdl_waiting == 1);
            mreq = sel ? d_req : i_req;
        end else if (!full) begin
            if (i_req && d_req) begin
                sel  = !mdl_last;
                mreq = 1'b1;
            end else if (i_req || d_req) begin
                sel  = d_req;
                mreq = 1'b1;
            end
        end
        acc  = mreq && m_aok;
        dv   = m_dok && !was_empty;
        head = was_empty ? 1'b0 : idq[0];
        pl   = sel ? d_pl : i_pl;

        chk("mem_req", 32'(mem_b.req), 32'(mreq));
        if (mreq) begin
            chk("mem_wr",    32'(mem_b.wr),    32'(pl.wr));
            chk("mem_size",  32'(mem_b.size),  32'(pl.size));
            chk("mem_wstrb", 32'(mem_b.wstrb), 32'(pl.wstrb));
            chk("mem_addr",  mem_b.addr,       pl.addr);
            chk("mem_wdata", mem_b.wdata,      pl.wdata);
        end
        chk("inst_addr_ok", 32'(inst_b.addr_ok), 32'(acc && !sel));
        chk("data_addr_ok", 32'(data_b.addr_ok), 32'(acc && sel));
        chk("inst_data_ok", 32'(inst_b.data_ok), 32'(dv && !head));
        chk("data_data_ok", 32'(data_b.data_ok), 32'(dv && head));
        if (m_dok) begin
            chk("inst_rdata", inst_b.rdata, m_rdata);
            chk("data_rdata", data_b.rdata, m_rdata);
        end
        chk("resp_err", 32'(resp_err), 32'(mdl_err));

        acc_id = acc ? int'(sel) : -1;
        rsp_id = dv ? int'(head) : -1;
        if (dv) void'(idq.pop_front());
        if (acc) begin
            idq.push_back(sel);
            mdl_last = sel;
        end
        mdl_waiting = (mreq && !acc) ? int'(sel) : -1;
        if (m_dok && was_empty) mdl_err = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; m_aok = 1'b0; m_dok = 1'b0; m_rdata = '0;
        drive();
        @(negedge clk);
        #1;
        chk("rst_mem_req",      32'(mem_b.req),      32'd0);
        chk("rst_inst_addr_ok", 32'(inst_b.addr_ok), 32'd0);
        chk("rst_data_addr_ok", 32'(data_b.addr_ok), 32'd0);
        chk("rst_inst_data_ok", 32'(inst_b.data_ok), 32'd0);
        chk("rst_data_data_ok", 32'(data_b.data_ok), 32'd0);
        chk("rst_resp_err",     32'(resp_err),       32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic mem_req_t rand_pl();
        mem_req_t p;
        p.wr    = 1'($urandom);
        p.size  = 2'($urandom_range(0, 2));
        p.wstrb = 4'($urandom);
        p.addr  = $urandom;
        p.wdata = $urandom;
        return p;
    endfunction

    initial begin
        bit i_pend, d_pend;
        i_pl = '0; d_pl = '0;
        model_reset();

        // single instruction read routed back two cycles later
        do_reset();
        i_pl  = '{wr: 1'b0, size: SZ_W, wstrb: 4'hf, addr: 32'h1C00_0000, wdata: 32'h0};
        i_req = 1'b1; m_aok = 1'b1;
        step();
        chk("t1_inst_addr_ok", 32'(inst_b.addr_ok), 32'd1);
        chk("t1_mem_addr", mem_b.addr, 32'h1C00_0000);
        i_req = 1'b0; m_aok = 1'b0;
        step();
        m_dok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        step();
        chk("t1_inst_data_ok", 32'(inst_b.data_ok), 32'd1);
        chk("t1_inst_rdata", inst_b.rdata, 32'hDEAD_BEEF);
        chk("t1_data_data_ok", 32'(data_b.data_ok), 32'd0);
        m_dok = 1'b0;

        // continuous contention alternates starting with DATA; responses follow grant order
        do_reset();
        i_pl = rand_pl(); d_pl = rand_pl();
        i_req = 1'b1; d_req = 1'b1; m_aok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_grant%0d", k), 32'(acc_id), 32'((k % 2 == 0) ? 1 : 0));
        end
        i_req = 1'b0; d_req = 1'b0; m_aok = 1'b0; m_dok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_rdata = $urandom;
            step();
            chk($sformatf("t2_resp%0d", k), 32'(rsp_id), 32'((k % 2 == 0) ? 1 : 0));
        end
        m_dok = 1'b0;

        // data store held off by the memory for three cycles while INST waits
        do_reset();
        d_pl  = '{wr: 1'b1, size: SZ_H, wstrb: 4'h3, addr: 32'h80, wdata: 32'h1234};
        i_pl  = rand_pl();
        d_req = 1'b1; m_aok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k >= 1) i_req = 1'b1;
            if (k == 3) m_aok = 1'b1;
            step();
            chk($sformatf("t3_addr%0d", k), mem_b.addr, 32'h80);
            chk($sformatf("t3_wdata%0d", k), mem_b.wdata, 32'h1234);
            chk($sformatf("t3_inst_aok%0d", k), 32'(inst_b.addr_ok), 32'd0);
        end
        chk("t3_data_aok", 32'(data_b.addr_ok), 32'd1);
        d_req = 1'b0;
        step();
        chk("t3_inst_after", 32'(inst_b.addr_ok), 32'd1);
        i_req = 1'b0; m_aok = 1'b0;

        // FIFO full blocks the fifth request until a response has popped
        do_reset();
        i_pl = rand_pl(); i_req = 1'b1; m_aok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t4_acc%0d", k), 32'(inst_b.addr_ok), 32'd1);
        end
        step();
        chk("t4_full_req", 32'(mem_b.req), 32'd0);
        m_dok = 1'b1; m_rdata = 32'h0BAD_F00D;
        step();
        chk("t4_full_pop_req", 32'(mem_b.req), 32'd0);
        chk("t4_pop_dok", 32'(inst_b.data_ok), 32'd1);
        m_dok = 1'b0;
        step();
        chk("t4_fifth_grant", 32'(inst_b.addr_ok), 32'd1);
        i_req = 1'b0; m_aok = 1'b0;

        // response with nothing outstanding sets a sticky error
        do_reset();
        m_dok = 1'b1; m_rdata = 32'h5555_AAAA;
        step();
        chk("t5_inst_dok", 32'(inst_b.data_ok), 32'd0);
        chk("t5_data_dok", 32'(data_b.data_ok), 32'd0);
        m_dok = 1'b0;
        step();
        chk("t5_err_set", 32'(resp_err), 32'd1);
        step();
        chk("t5_err_sticky", 32'(resp_err), 32'd1);
        do_reset();

        // randomized traffic with protocol-respecting requesters and a random memory
        i_pend = 1'b0; d_pend = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!i_pend && ($urandom % 3 == 0)) begin i_pend = 1'b1; i_pl = rand_pl(); end
            else if (i_pend && ($urandom % 64 == 0)) i_pend = 1'b0;
            if (!d_pend && ($urandom % 3 == 0)) begin d_pend = 1'b1; d_pl = rand_pl(); end
            else if (d_pend && ($urandom % 64 == 0)) d_pend = 1'b0;
            i_req   = i_pend;
            d_req   = d_pend;
            m_aok   = ($urandom % 4 != 0);
            m_dok   = (idq.size() > 0) && ($urandom % 2 == 0);
            m_rdata = $urandom;
            step();
            if (acc_id == 0) i_pend = 1'b0;
            if (acc_id == 1) d_pend = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
